collision_engine: RTL and testbench

- Parametrised successor to the four-cell tetromino collision checker.
- Takes a move request (down, left, right or rotate) for the active piece at an anchor position. The caller supplies the candidate cell offsets.
- Probes the board RAM one cell per cycle and adds explicit board-bound checks.
- Returns the resolved anchor plus a blocked/landed verdict over a start/done handshake.
- Sits between the game control FSM and the board RAM.

---
 rtl/collision_engine.sv | 218 +++++++++++++++++++++
 tb/tb_collision_engine.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/collision_engine.sv
// collision_engine: probes the four target cells of a tetromino move against
// the board bounds and the board RAM, one RAM read issued per cycle, and
// returns the resolved anchor plus a blocked/landed verdict.
//
// Handshake: start is sampled only in IDLE. The accepting edge is E_0, and busy
// rises on that edge. done is a one-cycle pulse. The result outputs are valid
// while done is high and hold until the next done. busy falls on the edge that
// raises done.
//
// Optional feature: define COLLISION_WALL_KICK_EN to retry a blocked rotate at
// shift -1 and then +1 before rejecting it.
module collision_engine #(
  parameter int BOARD_W = 10,
  parameter int BOARD_H = 24,
  parameter int XW      = 5,
  parameter int YW      = 6,
  parameter int OW      = 2,
  parameter int CW      = 6,
  parameter int AW      = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      cmd,
  input  logic [XW-1:0]   x_anchor,
  input  logic [YW-1:0]   y_anchor,
  input  logic [4*OW-1:0] cell_dx,
  input  logic [4*OW-1:0] cell_dy,
  output logic [AW-1:0]   ram_addr,
  input  logic [CW-1:0]   ram_q,
  output logic            busy,
  output logic            done,
  output logic            blocked,
  output logic            landed,
  output logic [XW-1:0]   x_out,
  output logic [YW-1:0]   y_out,
  output logic [1:0]      state_dbg
);

  typedef enum logic [1:0] {IDLE, PROBE, EVAL, RETRY} state_t;

  localparam logic signed [XW+1:0] BW_S = (XW+2)'(BOARD_W);
  localparam logic signed [YW+1:0] BH_S = (YW+2)'(BOARD_H);

  state_t            state;
  logic [1:0]        cmd_r;
  logic [XW-1:0]     x_r;
  logic [YW-1:0]     y_r;
  logic [4*OW-1:0]   dx_r, dy_r;
  logic signed [1:0] shift;
  logic [1:0]        issue_idx, eval_cnt;
  logic              v_issue, oob_issue, v_data, oob_data, hit;

  logic [1:0]          src_cmd, src_idx;
  logic [XW-1:0]       src_x;
  logic [YW-1:0]       src_y;
  logic [4*OW-1:0]     src_dx, src_dy;
  logic signed [1:0]   src_shift, kick_shift;
  logic [OW-1:0]       off_dx, off_dy;
  logic signed [XW+1:0] tx;
  logic signed [YW+1:0] ty;
  logic                t_oob;
  logic [AW-1:0]       t_addr;
  logic                hit_next;

  assign state_dbg = state;

  // Horizontal move delta: down 0, left -1, right +1, rotate by the kick shift.
  function automatic logic signed [XW+1:0] delta_x(input logic [1:0] c,
                                                    input logic signed [1:0] s);
    case (c)
      2'b01:   delta_x = '1;
      2'b10:   delta_x = (XW+2)'(1);
      2'b11:   delta_x = {{XW{s[1]}}, s};
      default: delta_x = '0;
    endcase
  endfunction

  // Rotate retries go 0, then -1, then +1.
  assign kick_shift = (shift == 2'sd0) ? -2'sd1 : 2'sd1;

  // Cell 0 comes from the live inputs on the accepting edge. Cell 0 of a
  // kick retry comes from EVAL with the next shift. Every other cell comes
  // from the latched request.
  always_comb begin
    src_cmd   = cmd_r;
    src_x     = x_r;
    src_y     = y_r;
    src_dx    = dx_r;
    src_dy    = dy_r;
    src_idx   = issue_idx;
    src_shift = shift;
    if (state == IDLE) begin
      src_cmd   = cmd;
      src_x     = x_anchor;
      src_y     = y_anchor;
      src_dx    = cell_dx;
      src_dy    = cell_dy;
      src_idx   = 2'd0;
      src_shift = 2'sd0;
    end else if (state == EVAL) begin
      src_idx   = 2'd0;
      src_shift = kick_shift;
    end
  end

  // Target cell coordinates, bounds check and linear RAM address. The
  // coordinates are kept signed and two bits wide of the anchor, so that a
  // left move off column 0 reads as negative instead of wrapping.
  always_comb begin
    off_dx = src_dx[src_idx*OW +: OW];
    off_dy = src_dy[src_idx*OW +: OW];
    tx = $signed({2'b00, src_x}) + $signed({{(XW+2-OW){1'b0}}, off_dx})
         + delta_x(src_cmd, src_shift);
    ty = $signed({2'b00, src_y}) + $signed({{(YW+2-OW){1'b0}}, off_dy})
         + $signed({{(YW+1){1'b0}}, (src_cmd == 2'b00)});
    t_oob  = (tx < 0) || (tx >= BW_S) || (ty >= BH_S);
    t_addr = t_oob ? '0 : (AW'(ty) * AW'(BOARD_W) + AW'(tx));
  end

  // A cell that is out of bounds is blocked without looking at ram_q.
  // Its slot reads address 0, and that data is ignored.
  assign hit_next = hit | (v_data & (oob_data | (|ram_q)));

  // Control FSM plus a two-stage issue/data pipeline. Cell i is issued at E_i
  // and evaluated at E_{i+2}.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ram_addr  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      blocked   <= 1'b0;
      landed    <= 1'b0;
      x_out     <= '0;
      y_out     <= '0;
      cmd_r     <= '0;
      x_r       <= '0;
      y_r       <= '0;
      dx_r      <= '0;
      dy_r      <= '0;
      shift     <= 2'sd0;
      issue_idx <= '0;
      eval_cnt  <= '0;
      v_issue   <= 1'b0;
      oob_issue <= 1'b0;
      v_data    <= 1'b0;
      oob_data  <= 1'b0;
      hit       <= 1'b0;
    end else begin
      done      <= 1'b0;
      v_data    <= v_issue;
      oob_data  <= oob_issue;
      v_issue   <= 1'b0;
      oob_issue <= 1'b0;
      if (v_data) begin
        hit      <= hit_next;
        eval_cnt <= eval_cnt + 2'd1;
      end
      case (state)
        IDLE: begin
          if (start) begin
            cmd_r     <= cmd;
            x_r       <= x_anchor;
            y_r       <= y_anchor;
            dx_r      <= cell_dx;
            dy_r      <= cell_dy;
            shift     <= 2'sd0;
            hit       <= 1'b0;
            eval_cnt  <= '0;
            issue_idx <= 2'd1;
            ram_addr  <= t_addr;
            v_issue   <= 1'b1;
            oob_issue <= t_oob;
            busy      <= 1'b1;
            state     <= PROBE;
          end
        end
        PROBE, RETRY: begin
          ram_addr  <= t_addr;
          v_issue   <= 1'b1;
          oob_issue <= t_oob;
          issue_idx <= issue_idx + 2'd1;
          if (issue_idx == 2'd3) state <= EVAL;
        end
        EVAL: begin
          if (v_data && eval_cnt == 2'd3) begin
`ifdef COLLISION_WALL_KICK_EN
            if (hit_next && cmd_r == 2'b11 && shift != 2'sd1) begin
              shift     <= kick_shift;
              hit       <= 1'b0;
              eval_cnt  <= '0;
              issue_idx <= 2'd1;
              ram_addr  <= t_addr;
              v_issue   <= 1'b1;
              oob_issue <= t_oob;
              state     <= RETRY;
            end else
`endif
            begin
              done    <= 1'b1;
              busy    <= 1'b0;
              blocked <= hit_next;
              landed  <= hit_next && (cmd_r == 2'b00);
              x_out   <= hit_next ? x_r
                         : XW'($signed({2'b00, x_r}) + delta_x(cmd_r, shift));
              y_out   <= hit_next ? y_r
                         : (y_r + YW'(cmd_r == 2'b00));
              state   <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_collision_engine.sv
// Directed bench for collision_engine. The driver issues moves and queues the
// hand-computed result and latency. The monitor checks every done pulse
// against that queue. A behavioural board RAM has a one-cycle read latency.
module tb_collision_engine;
  localparam int XW = 5;
  localparam int YW = 6;
  localparam int OW = 2;
  localparam int CW = 6;
  localparam int AW = 8;
  localparam int W  = 5 + 2 + YW + XW;

  localparam logic [7:0] O_DX = 8'h44;  // cells 0..3: 0,1,0,1
  localparam logic [7:0] O_DY = 8'h50;  // cells 0..3: 0,0,1,1
  localparam logic [7:0] I_H  = 8'hE4;  // cells 0..3: 0,1,2,3

  logic            clk = 1'b0;
  logic            reset, start;
  logic [1:0]      cmd;
  logic [XW-1:0]   x_anchor;
  logic [YW-1:0]   y_anchor;
  logic [4*OW-1:0] cell_dx, cell_dy;
  logic [AW-1:0]   ram_addr;
  logic [CW-1:0]   ram_q;
  logic            busy, done, blocked, landed;
  logic [XW-1:0]   x_out;
  logic [YW-1:0]   y_out;
  logic [1:0]      state_dbg;

  logic [CW-1:0]   mem [0:255];
  logic [W-1:0]    exp_q[$];
  int              st_q[$];
  int              cyc = 0;
  int              n_cmp = 0;
  int              n_bad = 0;

  collision_engine dut (
    .clk(clk), .reset(reset), .start(start), .cmd(cmd),
    .x_anchor(x_anchor), .y_anchor(y_anchor),
    .cell_dx(cell_dx), .cell_dy(cell_dy),
    .ram_addr(ram_addr), .ram_q(ram_q),
    .busy(busy), .done(done), .blocked(blocked), .landed(landed),
    .x_out(x_out), .y_out(y_out), .state_dbg(state_dbg)
  );

  // clock, cycle counter, board RAM
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) ram_q <= mem[ram_addr];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input int x, input int y, input bit b,
                                       input bit l, input int lat);
    mk = {5'(lat), l, b, YW'(y), XW'(x)};
  endfunction

  // monitor / scoreboard
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        logic [W-1:0] e;
        int st;
        e  = exp_q.pop_front();
        st = st_q.pop_front();
        chk("x_out",   x_out,   e[XW-1:0]);
        chk("y_out",   y_out,   e[XW +: YW]);
        chk("blocked", blocked, e[XW+YW]);
        chk("landed",  landed,  e[XW+YW+1]);
        chk("latency", cyc - st, e[W-1 -: 5]);
      end
    end
  end

  // drive one request; returns just after the accepting edge
  task automatic issue(input int x, input int y, input logic [7:0] dx,
                       input logic [7:0] dy, input logic [1:0] c,
                       input bit push, input logic [W-1:0] e);
    x_anchor = XW'(x);
    y_anchor = YW'(y);
    cell_dx  = dx;
    cell_dy  = dy;
    cmd      = c;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (push) begin
      exp_q.push_back(e);
      st_q.push_back(cyc);
    end
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (!busy) return;
    end
    chk("busy_timeout", 1, 0);
  endtask

  task automatic move(input int x, input int y, input logic [7:0] dx,
                      input logic [7:0] dy, input logic [1:0] c,
                      input logic [W-1:0] e);
    issue(x, y, dx, dy, c, 1'b1, e);
    wait_idle();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    reset = 1'b1; start = 1'b0; cmd = '0;
    x_anchor = '0; y_anchor = '0; cell_dx = '0; cell_dy = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_blocked", blocked, 0);
    chk("rst_landed", landed, 0);
    chk("rst_x", x_out, 0);
    chk("rst_y", y_out, 0);
    chk("rst_addr", ram_addr, 0);

    // O-piece down on empty board, with the probe address sequence
    issue(4, 0, O_DX, O_DY, 2'b00, 1'b1, mk(4, 1, 0, 0, 5));
    chk("addr_c0", ram_addr, 14);
    @(posedge clk); #1 chk("addr_c1", ram_addr, 15);
    @(posedge clk); #1 chk("addr_c2", ram_addr, 24);
    @(posedge clk); #1 chk("addr_c3", ram_addr, 25);
    wait_idle();

    move(0, 0, O_DX, O_DY, 2'b01, mk(0, 0, 1, 0, 5));  // left wall
    move(8, 0, O_DX, O_DY, 2'b10, mk(8, 0, 1, 0, 5));  // right wall
    move(4, 1, O_DX, O_DY, 2'b01, mk(3, 1, 0, 0, 5));  // left accepted
    mem[35] = 6'd7;                                     // cell (5,3)
    move(4, 1, O_DX, O_DY, 2'b00, mk(4, 1, 1, 1, 5));  // lands on (5,3)
    move(2, 5, O_DX, O_DY, 2'b10, mk(3, 5, 0, 0, 5));  // right accepted

`ifdef COLLISION_WALL_KICK_EN
    move(9, 2, I_H, 8'h00, 2'b11, mk(9, 2, 1, 0, 15));
    move(7, 2, I_H, 8'h00, 2'b11, mk(6, 2, 0, 0, 10));
`else
    move(9, 2, I_H, 8'h00, 2'b11, mk(9, 2, 1, 0, 5));
    move(7, 2, I_H, 8'h00, 2'b11, mk(7, 2, 1, 0, 5));
`endif
    move(2, 2, I_H, 8'h00, 2'b11, mk(2, 2, 0, 0, 5));  // rotate in open space

    move(0, 21, O_DX, O_DY, 2'b00, mk(0, 22, 0, 0, 5)); // onto the bottom row
    // bottom row: the lower cells land at ty=24 and must not touch the RAM
    issue(0, 22, O_DX, O_DY, 2'b00, 1'b1, mk(0, 22, 1, 1, 5));
    chk("bot_c0", ram_addr, 230);
    @(posedge clk); #1 chk("bot_c1", ram_addr, 231);
    @(posedge clk); #1 chk("bot_c2", ram_addr, 0);
    @(posedge clk); #1 chk("bot_c3", ram_addr, 0);
    wait_idle();

    // start again at E_2: ignored, original request completes once
    issue(4, 0, O_DX, O_DY, 2'b00, 1'b1, mk(4, 1, 0, 0, 5));
    @(negedge clk);
    @(negedge clk);
    x_anchor = '0; cmd = 2'b01; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_idle();
    repeat (4) @(negedge clk);

    // reset at E_3: abort with no done
    issue(4, 0, O_DX, O_DY, 2'b00, 1'b0, '0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", busy, 0);
    chk("abort_addr", ram_addr, 0);
    chk("abort_x", x_out, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);

    move(4, 0, O_DX, O_DY, 2'b00, mk(4, 1, 0, 0, 5));  // recovers after abort
    repeat (3) @(negedge clk);
    chk("pending_results", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
